// File: rtl/memory.sv
// Memory-access pipeline stage: issues req/ack data-bus transactions for
// loads and stores, aligns/extends load data, flags misaligned accesses and
// registers results plus writeback control for the writeback stage.
module memory (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] next_pc_in,
  input  logic [31:0] alu_data_in,
  input  logic [31:0] alu_addition_in,
  input  logic [31:0] rs2_data_in,
  input  logic [31:0] csr_data_in,
  input  logic [4:0]  mem_ctrl_in,
  input  logic [21:0] wb_ctrl_in,
  input  logic        valid_in,
  input  logic [3:0]  ecause_in,
  input  logic        exception_in,
  input  logic        stall,
  input  logic        invalidate,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        busy,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [31:0] result_out,
  output logic [31:0] csr_data_out,
  output logic [21:0] wb_ctrl_out,
  output logic        valid_out,
  output logic [3:0]  ecause_out,
  output logic        exception_out
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, ABORT} state_t;

  state_t state_q, state_d;

  // Decoded memory control from execute
  logic       ld, st, sgn;
  logic [1:0] sz, off;
  logic       mem_op, misal, go, req_idle;

  assign {ld, st, sz, sgn} = mem_ctrl_in;
  assign off      = alu_addition_in[1:0];
  assign mem_op   = valid_in && (ld || st) && !exception_in;
  assign misal    = (sz == 2'b01 && off[0]) || (sz[1] && off != 2'b00);
  assign go       = mem_op && !misal;
  // Reset also gates the combinational request so the bus goes quiet at once.
  assign req_idle = go && !stall && !invalidate && !reset;

  // Fields latched when a request has to wait for its ack
  logic        we_q, ld_q, lsgn_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  lsz_q, loff_q;

  // Output registers
  logic [31:0] pc_q, next_pc_q, result_q, csr_q;
  logic [21:0] wb_q;
  logic        valid_q, exc_q;
  logic [3:0]  cause_q;

  // Store lane replication and byte enables
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  always_comb begin
    st_wdata = rs2_data_in;
    st_wstrb = 4'b1111;
    if (!sz[1]) begin
      if (sz[0]) begin
        st_wdata = {2{rs2_data_in[15:0]}};
        st_wstrb = 4'b0011 << off;
      end else begin
        st_wdata = {4{rs2_data_in[7:0]}};
        st_wstrb = 4'b0001 << off;
      end
    end
  end

  // Bus drive: live from inputs in IDLE, latched fields while waiting
  always_comb begin
    dmem_req   = 1'b0;
    dmem_we    = we_q;
    dmem_addr  = addr_q;
    dmem_wdata = wdata_q;
    dmem_wstrb = wstrb_q;
    if (state_q == IDLE) begin
      dmem_req   = req_idle;
      dmem_we    = st;
      dmem_addr  = {alu_addition_in[31:2], 2'b00};
      dmem_wdata = st_wdata;
      dmem_wstrb = st ? st_wstrb : 4'b0000;
    end else if (state_q == WAIT || state_q == ABORT) begin
      dmem_req = 1'b1;
    end
  end

  assign busy = ((state_q == IDLE) && req_idle && !dmem_ack) ||
                ((state_q == WAIT || state_q == ABORT) && !dmem_ack);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_idle && !dmem_ack) state_d = WAIT;
      WAIT:    if (dmem_ack)              state_d = (stall && !invalidate) ? DONE : IDLE;
               else if (invalidate)       state_d = ABORT;
      DONE:    if (!stall || invalidate)  state_d = IDLE;
      ABORT:   if (dmem_ack)              state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // Load alignment: lane select then sign/zero extension
  logic        is_ld, a_sgn;
  logic [1:0]  a_sz, a_off;
  logic [31:0] raw, shifted, result_d;
  always_comb begin
    is_ld = ld_q;
    a_sgn = lsgn_q;
    a_sz  = lsz_q;
    a_off = loff_q;
    raw   = (state_q == DONE) ? rdata_q : dmem_rdata;
    if (state_q == IDLE) begin
      is_ld = go && ld;
      a_sgn = sgn;
      a_sz  = sz;
      a_off = off;
    end
    shifted = raw >> {a_off, 3'b000};
    case (a_sz)
      2'b00:   result_d = {{24{a_sgn && shifted[7]}},  shifted[7:0]};
      2'b01:   result_d = {{16{a_sgn && shifted[15]}}, shifted[15:0]};
      default: result_d = raw;
    endcase
    if (!is_ld) result_d = alu_data_in;
  end

  // Upstream exception wins over misalignment
  logic       exc_d;
  logic [3:0] cause_d;
  assign exc_d   = exception_in || (mem_op && misal);
  assign cause_d = exception_in ? ecause_in :
                   (mem_op && misal) ? (ld ? 4'd4 : 4'd6) : 4'd0;

  // ABORT completion discards its result, so it blocks the update like busy
  logic hold, upd;
  assign hold = busy || (state_q == ABORT);
  assign upd  = !stall && !hold;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Capture request fields on a waiting issue, buffer read data on a stalled ack
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_idle && !dmem_ack) begin
      we_q    <= st;
      addr_q  <= {alu_addition_in[31:2], 2'b00};
      wdata_q <= st_wdata;
      wstrb_q <= st ? st_wstrb : 4'b0000;
      ld_q    <= ld;
      lsz_q   <= sz;
      lsgn_q  <= sgn;
      loff_q  <= off;
    end
    if (state_q == WAIT && dmem_ack && stall) rdata_q <= dmem_rdata;
  end

  // Output registers toward writeback
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      exc_q     <= 1'b0;
      cause_q   <= 4'd0;
      result_q  <= 32'd0;
      wb_q      <= 22'd0;
      pc_q      <= 32'd0;
      next_pc_q <= 32'd0;
      csr_q     <= 32'd0;
    end else begin
      valid_q <= (stall ? valid_q : (valid_in && !hold)) && !invalidate;
      if (upd) begin
        exc_q     <= exc_d;
        cause_q   <= cause_d;
        result_q  <= result_d;
        wb_q      <= wb_ctrl_in;
        pc_q      <= pc_in;
        next_pc_q <= next_pc_in;
        csr_q     <= csr_data_in;
      end
    end
  end

  assign valid_out     = valid_q;
  assign exception_out = exc_q;
  assign ecause_out    = cause_q;
  assign result_out    = result_q;
  assign wb_ctrl_out   = wb_q;
  assign pc_out        = pc_q;
  assign next_pc_out   = next_pc_q;
  assign csr_data_out  = csr_q;

endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for the memory stage: expected writeback results are queued
// as ops are driven and popped whenever valid_out is seen.
module tb_memory;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, next_pc_in, alu_data_in, alu_addition_in, rs2_data_in, csr_data_in;
  logic [4:0]  mem_ctrl_in;
  logic [21:0] wb_ctrl_in;
  logic        valid_in, exception_in, stall, invalidate, dmem_ack;
  logic [3:0]  ecause_in;
  logic [31:0] dmem_rdata;
  logic        dmem_req, dmem_we, busy, valid_out, exception_out;
  logic [31:0] dmem_addr, dmem_wdata, pc_out, next_pc_out, result_out, csr_data_out;
  logic [3:0]  dmem_wstrb, ecause_out;
  logic [21:0] wb_ctrl_out;

  memory dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .next_pc_in(next_pc_in),
    .alu_data_in(alu_data_in), .alu_addition_in(alu_addition_in),
    .rs2_data_in(rs2_data_in), .csr_data_in(csr_data_in), .mem_ctrl_in(mem_ctrl_in),
    .wb_ctrl_in(wb_ctrl_in), .valid_in(valid_in), .ecause_in(ecause_in),
    .exception_in(exception_in), .stall(stall), .invalidate(invalidate),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .busy(busy), .pc_out(pc_out), .next_pc_out(next_pc_out),
    .result_out(result_out), .csr_data_out(csr_data_out), .wb_ctrl_out(wb_ctrl_out),
    .valid_out(valid_out), .ecause_out(ecause_out), .exception_out(exception_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] pc;
    logic        exc;
    logic [3:0]  cause;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] alu_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    valid_in = 1'b0; mem_ctrl_in = 5'd0; stall = 1'b0; invalidate = 1'b0;
    dmem_ack = 1'b0; exception_in = 1'b0; ecause_in = 4'd0; dmem_rdata = 32'd0;
  endtask

  task automatic drive_op(input logic ld, input logic st, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] rs2,
                          input logic [31:0] pcv);
    valid_in        = 1'b1;
    mem_ctrl_in     = {ld, st, sz, sg};
    alu_addition_in = a;
    alu_data_in     = alu_of(a);
    rs2_data_in     = rs2;
    pc_in           = pcv;
    next_pc_in      = pcv + 32'd4;
    csr_data_in     = ~pcv;
    wb_ctrl_in      = pcv[21:0];
  endtask

  task automatic sb_push(input logic [31:0] res, input logic [31:0] pcv,
                         input logic exc, input logic [3:0] cause);
    exp_t e;
    e.res = res; e.pc = pcv; e.exc = exc; e.cause = cause;
    sb.push_back(e);
  endtask

  // Writeback-side monitor: every valid_out must match the oldest queued op
  always @(negedge clk) begin
    if (!reset && valid_out) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: valid_out=1 pc_out=%h with empty scoreboard", pc_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (exception_out !== e.exc || ecause_out !== e.cause) begin
          errors++;
          $display("FAIL sb_exc pc=%h: got exc=%b cause=%0d want exc=%b cause=%0d",
                   e.pc, exception_out, ecause_out, e.exc, e.cause);
        end
        checks++;
        if (pc_out !== e.pc || next_pc_out !== e.pc + 32'd4 || csr_data_out !== ~e.pc ||
            wb_ctrl_out !== e.pc[21:0]) begin
          errors++;
          $display("FAIL sb_passthru pc=%h: got pc=%h npc=%h csr=%h wb=%h",
                   e.pc, pc_out, next_pc_out, csr_data_out, wb_ctrl_out);
        end
        if (!e.exc) begin
          checks++;
          if (result_out !== e.res) begin
            errors++;
            $display("FAIL sb_result pc=%h: got %h want %h", e.pc, result_out, e.res);
          end
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'd0, 32'hDEAD_BEE0);
    valid_in = 1'b0;
    tick(); tick(); #1;
    checks++;
    if ({valid_out, exception_out, ecause_out} !== 6'd0) begin
      errors++;
      $display("FAIL reset_flags: valid=%b exc=%b cause=%0d want 0", valid_out, exception_out, ecause_out);
    end
    checks++;
    if ({result_out, pc_out, next_pc_out, csr_data_out, wb_ctrl_out} !== 150'd0) begin
      errors++;
      $display("FAIL reset_data: res=%h pc=%h npc=%h csr=%h wb=%h want 0",
               result_out, pc_out, next_pc_out, csr_data_out, wb_ctrl_out);
    end
    checks++;
    if (dmem_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus: req=%b busy=%b want 0", dmem_req, busy);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_lb_wait();
    tick();
    drive_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'd0, 32'h0000_1000);
    sb_push(32'hFFFF_FF80, 32'h0000_1000, 1'b0, 4'd0);
    #1;
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h100 ||
        dmem_wstrb !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL lb_issue: req=%b we=%b addr=%h wstrb=%b busy=%b want 1 0 00000100 0000 1",
               dmem_req, dmem_we, dmem_addr, dmem_wstrb, busy);
    end
    tick(); #1;
    checks++;
    if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || busy !== 1'b1) begin
      errors++;
      $display("FAIL lb_wait: req=%b addr=%h busy=%b want 1 00000100 1", dmem_req, dmem_addr, busy);
    end
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'h80FF_1234;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL lb_ack_busy: busy=%b want 0", busy);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (valid_out !== 1'b1 || result_out !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL lb_result: valid=%b res=%h want 1 ffffff80", valid_out, result_out);
    end
    tick();
  endtask

  task automatic test_sh_zero_wait();
    tick();
    drive_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h0000_2000);
    dmem_ack = 1'b1;
    sb_push(alu_of(32'h0000_0202), 32'h0000_2000, 1'b0, 4'd0);
    #1;
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h200 ||
        dmem_wdata !== 32'hABCD_ABCD || dmem_wstrb !== 4'b1100 || busy !== 1'b0) begin
      errors++;
      $display("FAIL sh_bus: req=%b we=%b addr=%h wdata=%h wstrb=%b busy=%b want 1 1 00000200 abcdabcd 1100 0",
               dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, busy);
    end
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_misaligned();
    tick();
    drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0105, 32'd0, 32'h0000_3000);
    sb_push(32'd0, 32'h0000_3000, 1'b1, 4'd4);
    #1;
    checks++;
    if (dmem_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL lw_misal_req: req=%b busy=%b want 0 0", dmem_req, busy);
    end
    tick();
    drive_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h1234_5678, 32'h0000_3004);
    sb_push(32'd0, 32'h0000_3004, 1'b1, 4'd6);
    #1;
    checks++;
    if (dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL sw_misal_req: req=%b want 0", dmem_req);
    end
    tick();
    drive_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0003, 32'd0, 32'h0000_3008);
    sb_push(32'd0, 32'h0000_3008, 1'b1, 4'd4);
    #1;
    checks++;
    if (dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL lh_misal_req: req=%b want 0", dmem_req);
    end
    tick();
    drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0105, 32'd0, 32'h0000_300C);
    exception_in = 1'b1; ecause_in = 4'd2;
    sb_push(32'd0, 32'h0000_300C, 1'b1, 4'd2);
    #1;
    checks++;
    if (dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL upstream_exc_req: req=%b want 0", dmem_req);
    end
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_abort();
    tick();
    drive_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'h1122_3344, 32'h0000_4000);
    #1;
    checks++;
    if (dmem_req !== 1'b1 || busy !== 1'b1 || dmem_wstrb !== 4'b1111 || dmem_wdata !== 32'h1122_3344) begin
      errors++;
      $display("FAIL sw_issue: req=%b busy=%b wstrb=%b wdata=%h want 1 1 1111 11223344",
               dmem_req, busy, dmem_wstrb, dmem_wdata);
    end
    tick();
    valid_in = 1'b0; invalidate = 1'b1; mem_ctrl_in = 5'd0;
    alu_addition_in = 32'h9999_9998; rs2_data_in = 32'd0;
    #1;
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h300 ||
        dmem_wdata !== 32'h1122_3344 || dmem_wstrb !== 4'b1111 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_inval_hold: req=%b we=%b addr=%h wdata=%h wstrb=%b busy=%b",
               dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, busy);
    end
    tick();
    invalidate = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h300 ||
        dmem_wdata !== 32'h1122_3344 || dmem_wstrb !== 4'b1111 || busy !== 1'b1 ||
        valid_out !== 1'b0) begin
      errors++;
      $display("FAIL abort_hold: req=%b we=%b addr=%h wdata=%h wstrb=%b busy=%b valid=%b",
               dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, busy, valid_out);
    end
    tick();
    dmem_ack = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_ack: req=%b busy=%b want 1 0", dmem_req, busy);
    end
    tick();
    dmem_ack = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || busy !== 1'b0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL abort_after: req=%b busy=%b valid=%b want 0 0 0", dmem_req, busy, valid_out);
    end
    tick(); #1;
    checks++;
    if (dmem_req !== 1'b0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_rereq: req=%b valid=%b want 0 0", dmem_req, valid_out);
    end
  endtask

  task automatic test_done_stall();
    tick();
    drive_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'd0, 32'h0000_5000);
    sb_push(32'h0000_BEEF, 32'h0000_5000, 1'b0, 4'd0);
    #1;
    checks++;
    if (dmem_req !== 1'b1 || busy !== 1'b1 || dmem_addr !== 32'h0) begin
      errors++;
      $display("FAIL lhu_issue: req=%b busy=%b addr=%h want 1 1 00000000", dmem_req, busy, dmem_addr);
    end
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'hBEEF_0000; stall = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL lhu_ack_busy: busy=%b want 0", busy);
    end
    tick();
    dmem_ack = 1'b0; dmem_rdata = 32'h1234_5678;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || busy !== 1'b0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL done_stalled: req=%b busy=%b valid=%b want 0 0 0", dmem_req, busy, valid_out);
    end
    tick(); #1;
    checks++;
    if (dmem_req !== 1'b0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL done_stalled2: req=%b valid=%b want 0 0", dmem_req, valid_out);
    end
    tick();
    stall = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL done_release_req: req=%b want 0", dmem_req);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (valid_out !== 1'b1 || result_out !== 32'h0000_BEEF) begin
      errors++;
      $display("FAIL lhu_result: valid=%b res=%h want 1 0000beef", valid_out, result_out);
    end
    tick();
  endtask

  task automatic test_reset_in_wait();
    tick();
    drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'd0, 32'h0000_6000);
    #1;
    checks++;
    if (dmem_req !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_issue: req=%b busy=%b want 1 1", dmem_req, busy);
    end
    tick(); tick();
    reset = 1'b1; valid_in = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || busy !== 1'b0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait: req=%b busy=%b valid=%b want 0 0 0", dmem_req, busy, valid_out);
    end
    tick();
    drive_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0401, 32'd0, 32'h0000_6004);
    dmem_ack = 1'b1; dmem_rdata = 32'h0000_A500;
    sb_push(32'h0000_00A5, 32'h0000_6004, 1'b0, 4'd0);
    #1;
    checks++;
    if (dmem_req !== 1'b1 || busy !== 1'b0 || dmem_addr !== 32'h400) begin
      errors++;
      $display("FAIL rst_idle_op: req=%b busy=%b addr=%h want 1 0 00000400", dmem_req, busy, dmem_addr);
    end
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_back_to_back();
    tick();
    drive_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0000, 32'd0, 32'h0000_7000);
    dmem_ack = 1'b1; dmem_rdata = 32'h0000_007F;
    sb_push(32'h0000_007F, 32'h0000_7000, 1'b0, 4'd0);
    tick();
    drive_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'd0, 32'h0000_7004);
    dmem_rdata = 32'h8001_0000;
    sb_push(32'hFFFF_8001, 32'h0000_7004, 1'b0, 4'd0);
    #1;
    checks++;
    if (busy !== 1'b0 || dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL b2b_lh: busy=%b req=%b want 0 1", busy, dmem_req);
    end
    tick();
    drive_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h0000_00C3, 32'h0000_7008);
    sb_push(alu_of(32'h0000_0001), 32'h0000_7008, 1'b0, 4'd0);
    #1;
    checks++;
    if (dmem_wdata !== 32'hC3C3_C3C3 || dmem_wstrb !== 4'b0010 || dmem_we !== 1'b1) begin
      errors++;
      $display("FAIL b2b_sb: wdata=%h wstrb=%b we=%b want c3c3c3c3 0010 1", dmem_wdata, dmem_wstrb, dmem_we);
    end
    tick();
    set_idle();
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_lb_wait();
    test_sh_zero_wait();
    test_misaligned();
    test_abort();
    test_done_stall();
    test_reset_in_wait();
    test_back_to_back();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d results never produced, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory.md
Name: memory

Overview:
Memory-access pipeline stage directly downstream of execute and upstream of writeback. It consumes execute's registered outputs and runs a req/ack transaction on the data bus for loads and stores. It aligns and extends load data, detects misaligned accesses, and registers results and writeback control for the writeback stage. It reports `busy` to the hazard unit while a bus access is outstanding.

Parameters:
None. The datapath is fixed at 32 bits.

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
pc_in  input  32  instruction PC from execute
next_pc_in  input  32  sequential PC from execute
alu_data_in  input  32  ALU result
alu_addition_in  input  32  effective address (adder output)
rs2_data_in  input  32  store data
csr_data_in  input  32  CSR read value, passed through
mem_ctrl_in  input  5  {load, store, size[1:0], signed}; size 00=byte, 01=half, 1x=word
wb_ctrl_in  input  22  {write_select[1:0], rd_address[4:0], csr_address[11:0], csr_write, mret, wfi}, passed through
valid_in  input  1  instruction valid
ecause_in  input  4  upstream exception cause
exception_in  input  1  upstream exception
stall  input  1  hazard: hold this stage's outputs
invalidate  input  1  hazard: flush this stage
dmem_req  output  1  bus request
dmem_we  output  1  1=write
dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  output  32  lane-replicated store data
dmem_wstrb  output  4  byte enables (0000 on reads)
dmem_ack  input  1  transaction complete; read data valid this cycle
dmem_rdata  input  32  read data
busy  output  1  access outstanding; hazard stalls upstream stages
pc_out  output  32  registered pc_in
next_pc_out  output  32  registered next_pc_in
result_out  output  32  aligned and extended load data for loads, else alu_data_in
csr_data_out  output  32  registered csr_data_in
wb_ctrl_out  output  22  registered wb_ctrl_in
valid_out  output  1  valid to writeback
ecause_out  output  4  exception cause
exception_out  output  1  exception flag

Behaviour:
- A memory op is `valid_in && (load||store) && !exception_in`.
- Misaligned accesses:
  - Half with addr[0]=1, or word with addr[1:0]≠0, is misaligned.
  - No request is issued.
  - The output registers exception_out=1, ecause_out=4 (load) or 6 (store).
  - An upstream exception always takes precedence over misalignment.
- FSM states: IDLE, WAIT, DONE, ABORT.
- IDLE:
  - For an aligned memory op with !stall && !invalidate, dmem_req=1 combinationally from the inputs.
  - If dmem_ack is high the same cycle, the access completes and the outputs register at that edge.
  - Otherwise addr/we/wdata/wstrb are latched and the FSM goes to WAIT.
- WAIT:
  - dmem_req is held at 1 with the latched, stable fields until ack.
  - On ack: if stall=0, the outputs register and the FSM goes to IDLE.
  - If stall=1 on ack, rdata is buffered and the FSM goes to DONE.
- DONE:
  - No request is issued.
  - When stall=0, the outputs register from the buffer and the FSM goes to IDLE.
- ABORT:
  - Entered when invalidate is high in WAIT.
  - The request is held until ack, because a started store cannot be cancelled.
  - The result is discarded and the FSM then goes to IDLE.
- busy:
  - 1 in IDLE while a memory op is requested without ack.
  - 1 in WAIT without ack.
  - 1 in ABORT without ack.
  - 0 otherwise, including the ack cycle, so execute advances at the completion edge.
- Output register update:
  - valid_out <= (stall ? valid_out : (valid_in && !busy)) && !invalidate.
  - While busy, valid_out gets a bubble (0).
  - Other outputs update only when !stall && !busy.
- Store lanes:
  - byte: wdata = {4{rs2[7:0]}}, wstrb = 0001<<addr[1:0].
  - half: wdata = {2{rs2[15:0]}}, wstrb = 0011<<addr[1:0].
  - word: wdata = rs2, wstrb = 1111.
- Load: select lane by addr[1:0], then sign-extend if `signed`, else zero-extend.
- Reset:
  - State goes to IDLE.
  - dmem_req=0 from the next cycle; abandoning an in-flight request is a system-level contract.
  - valid_out, exception_out, ecause_out, result_out, wb_ctrl_out, pc_out, next_pc_out and csr_data_out all reset to 0.

Test Plan:
- LB signed, addr 0x103, rdata 0x80FF1234, ack after 2 wait cycles: busy=1 for 2 cycles, dmem_addr=0x100, dmem_wstrb=0000, then result_out=0xFFFFFF80 and valid_out=1 after the ack edge.
- SH, rs2=0x0000ABCD, addr 0x202, zero-wait ack: dmem_we=1, dmem_addr=0x200, dmem_wdata=0xABCDABCD, dmem_wstrb=1100, busy never asserted.
- LW at 0x105: no dmem_req, exception_out=1, ecause_out=4. SW at 0x102: exception_out=1, ecause_out=6.
- SW enters WAIT, then invalidate pulses 1 cycle: dmem_req is held with identical fields until ack, busy=1 until ack, valid_out=0, and no second request is issued.
- LHU at 0x002 with stall=1 at the ack cycle, rdata 0xBEEF0000: FSM enters DONE with no re-request; after stall drops, result_out=0x0000BEEF and valid_out=1.
- reset asserted during WAIT: next cycle dmem_req=0, busy=0, valid_out=0, state IDLE.
